// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard-side transmitter.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } ps2_state_e;

    localparam int   FRAME_BITS = 11;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Bit 0 of the result is transmitted first.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {STOP_BIT, ~^data, data, START_BIT};
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte FIFO feeding the PS/2 transmitter; power-of-two depth.
module ps2_tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic [7:0]                    din,
    input  logic                          pop,
    output logic [7:0]                    data_out,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign data_out = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    // NOTE: storage is not reset; the pointers and level alone define what is valid.
    always_ff @(posedge clk_sys) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: queues scancodes and drives 11-bit frames
// on registered clock/data lines, with an idle gap between frames.
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int PS2DIV     = 1103,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_BITS   = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       ps2_clk_out,
    output logic       ps2_dat_out,
    output logic       busy
);
    localparam int PH_W    = $clog2(PS2DIV);
    localparam int IDX_MAX = (FRAME_BITS > GAP_BITS) ? FRAME_BITS : GAP_BITS;
    localparam int IDX_W   = $clog2(IDX_MAX);
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(PS2DIV - 1);
    localparam logic [IDX_W-1:0] FRAME_LAST = IDX_W'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0] GAP_LAST   = IDX_W'(GAP_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

    ps2_state_e            state_q, state_d;
    logic                  load_q, load_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic                  half_q, half_d;      // 0: clock-high half, 1: clock-low half
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  din_ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  clk_q, clk_d;
    logic                  dat_q, dat_d;

    logic                  push;
    logic                  pop;
    logic [7:0]            fifo_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LVL_W-1:0]      fifo_level;
    logic [LVL_W-1:0]      level_d;
    logic [IDX_W-1:0]      idx_last;

    assign push = din_valid && din_ready_q && !fifo_full;

    ps2_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .push     (push),
        .din      (din),
        .pop      (pop),
        .data_out (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign idx_last = (state_q == FRAME) ? FRAME_LAST : GAP_LAST;

    // The pop cycle latches the frame; the following cycle starts it, so a
    // popped byte always gets one dedicated load cycle in IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        load_d  = load_q;
        phase_d = phase_q;
        half_d  = half_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_q) begin
                    state_d = FRAME;
                    load_d  = 1'b0;
                    phase_d = '0;
                    half_d  = 1'b0;
                    idx_d   = '0;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    load_d  = 1'b1;
                    frame_d = build_frame(fifo_data);
                end
            end
            FRAME, GAP: begin
                if (phase_q != PH_LAST) begin
                    phase_d = phase_q + PH_W'(1);
                end else begin
                    phase_d = '0;
                    half_d  = !half_q;
                    if (half_q) begin
                        if (idx_q != idx_last) begin
                            idx_d = idx_q + IDX_W'(1);
                        end else begin
                            idx_d   = '0;
                            state_d = (state_q == FRAME) ? GAP : IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so the lines move in step with the FSM.
    always_comb begin
        level_d = fifo_level + LVL_W'(push) - LVL_W'(pop);
        clk_d   = !((state_d == FRAME) && half_d);
        dat_d   = (state_d == FRAME) ? frame_d[idx_d] : 1'b1;
        busy_d  = (state_d != IDLE) || load_d || (level_d != '0);
        ready_d = (level_d != LVL_FULL);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            load_q      <= 1'b0;
            phase_q     <= '0;
            half_q      <= 1'b0;
            idx_q       <= '0;
            frame_q     <= '0;
            din_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            clk_q       <= 1'b1;
            dat_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            load_q      <= load_d;
            phase_q     <= phase_d;
            half_q      <= half_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            din_ready_q <= ready_d;
            busy_q      <= busy_d;
            clk_q       <= clk_d;
            dat_q       <= dat_d;
        end
    end

    assign din_ready   = din_ready_q;
    assign busy        = busy_q;
    assign ps2_clk_out = clk_q;
    assign ps2_dat_out = dat_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Scoreboard bench for ps2_kbd_tx: accepted bytes are queued as expectations,
// a line monitor decodes frames from the ps2 lines and compares them.
module tb_ps2_kbd_tx;

    localparam int PS2DIV     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP_BITS   = 2;
    localparam int FRAME_CYC  = 11 * 2 * PS2DIV;
    localparam int GAP_CYC    = GAP_BITS * 2 * PS2DIV;

    logic       clk_sys   = 1'b0;
    logic       reset_n   = 1'b0;
    logic [7:0] din       = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       ps2_clk_out;
    logic       ps2_dat_out;
    logic       busy;

    ps2_kbd_tx #(
        .PS2DIV     (PS2DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP_BITS   (GAP_BITS)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .ps2_clk_out (ps2_clk_out),
        .ps2_dat_out (ps2_dat_out),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame: start 0, data LSB first, parity making the one-count odd, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic p;
        p = (($countones(b) % 2) == 0);
        return {1'b1, p, b, 1'b0};
    endfunction

    // ---------------- line monitor ----------------
    logic        mon_prev_clk = 1'b1;
    logic        mon_prev_dat = 1'b1;
    bit          mon_in_frame = 1'b0;
    int          mon_bits     = 0;
    int          mon_low      = 0;
    int          mon_start    = 0;
    logic [10:0] mon_shift    = '0;
    logic [7:0]  mon_exp;

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            mon_in_frame = 1'b0;
            mon_bits     = 0;
            mon_low      = 0;
            mon_prev_clk = 1'b1;
            mon_prev_dat = 1'b1;
        end else begin
            if (!mon_in_frame && ps2_clk_out && !ps2_dat_out) begin
                mon_in_frame = 1'b1;
                mon_bits     = 0;
                mon_start    = cyc;
                start_q.push_back(cyc);
            end
            if (mon_prev_clk && !ps2_clk_out) begin
                mon_low = 1;
                check("clk_fall_in_frame", 32'(mon_in_frame && mon_bits < 11), 1);
                if (mon_in_frame && mon_bits < 11) begin
                    mon_shift[mon_bits] = ps2_dat_out;
                    mon_bits++;
                end
            end else if (!mon_prev_clk && !ps2_clk_out) begin
                mon_low++;
                check("dat_stable_clk_low", ps2_dat_out, mon_prev_dat);
            end else if (!mon_prev_clk && ps2_clk_out) begin
                check("clk_low_len", mon_low, PS2DIV);
                if (mon_in_frame && mon_bits == 11) begin
                    check("frame_len", cyc - mon_start, FRAME_CYC);
                    check("frame_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        mon_exp = exp_q.pop_front();
                        check("frame_bits", mon_shift, model_frame(mon_exp));
                    end
                    mon_in_frame = 1'b0;
                end
            end
            mon_prev_clk = ps2_clk_out;
            mon_prev_dat = ps2_dat_out;
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic send_byte(input logic [7:0] b, output int acc);
        int t = 0;
        din       = b;
        din_valid = 1'b1;
        while (!din_ready && t < 3000) begin
            @(negedge clk_sys);
            t++;
        end
        check("send_ready", din_ready, 1);
        acc = cyc + 1;
        if (din_ready) exp_q.push_back(b);
        @(negedge clk_sys);
        din_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int t = 0;
        while ((busy || exp_q.size() != 0) && t < limit) begin
            @(negedge clk_sys);
            t++;
        end
        check("idle_reached", 32'(busy || exp_q.size() != 0), 0);
    endtask

    task automatic wait_starts(input int n);
        int t = 0;
        while (start_q.size() < n && t < 3000) begin
            @(negedge clk_sys);
            t++;
        end
        check("start_seen", 32'(start_q.size() >= n), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int         acc;
        int         base;
        int         t;
        int         n_acc;
        int         r_cyc;
        logic [7:0] byt [6];

        repeat (3) @(negedge clk_sys);
        check("rst_clk", ps2_clk_out, 1);
        check("rst_dat", ps2_dat_out, 1);
        check("rst_ready", din_ready, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check("ready_after_release", din_ready, 1);
        check("busy_after_release", busy, 0);

        // Single byte 0x1C: latency, frame length, gap, busy drop.
        base = start_q.size();
        send_byte(8'h1C, acc);
        wait_starts(base + 1);
        if (start_q.size() > base) begin
            check("start_latency", start_q[base] - acc, 2);
            t = 0;
            while (busy && t < 500) begin
                @(negedge clk_sys);
                t++;
            end
            check("busy_drop_time", cyc - start_q[base], FRAME_CYC + GAP_CYC);
            check("idle_clk_high", ps2_clk_out, 1);
            check("idle_dat_high", ps2_dat_out, 1);
        end
        wait_idle(500);

        // All-ones byte: parity bit 1.
        @(negedge clk_sys);
        send_byte(8'hFF, acc);
        wait_idle(500);

        // Back-to-back bytes on consecutive edges.
        @(negedge clk_sys);
        base = start_q.size();
        send_byte(8'hF0, acc);
        send_byte(8'h1C, acc);
        wait_starts(base + 2);
        if (start_q.size() > base + 1)
            check("b2b_spacing", start_q[base + 1] - start_q[base], FRAME_CYC + GAP_CYC + 2);
        wait_idle(1000);

        // Streaming six random bytes with din_valid held high.
        for (int i = 0; i < 6; i++) byt[i] = 8'($urandom_range(0, 255));
        @(negedge clk_sys);
        base      = start_q.size();
        n_acc     = 0;
        din       = byt[0];
        din_valid = 1'b1;
        while (din_ready && n_acc < 6) begin
            exp_q.push_back(byt[n_acc]);
            n_acc++;
            @(negedge clk_sys);
            if (n_acc < 6) din = byt[n_acc];
        end
        check("accepted_before_full", n_acc, FIFO_DEPTH + 1);
        t = 0;
        while (!din_ready && t < 3000) begin
            @(negedge clk_sys);
            t++;
        end
        check("ready_returns", din_ready, 1);
        r_cyc = cyc;
        if (din_ready && n_acc < 6) begin
            exp_q.push_back(byt[n_acc]);
            n_acc++;
        end
        @(negedge clk_sys);
        din_valid = 1'b0;
        check("stream_total_accepted", n_acc, 6);
        wait_starts(base + 2);
        if (start_q.size() > base + 1)
            check("ready_after_pop", start_q[base + 1] - r_cyc, 1);
        wait_idle(3000);

        // Random bytes with random spacing.
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 120)) @(negedge clk_sys);
            send_byte(8'($urandom_range(0, 255)), acc);
        end
        wait_idle(3000);

        // Reset during bit 5 of a frame with two bytes still queued.
        @(negedge clk_sys);
        send_byte(8'hA5, acc);
        send_byte(8'h3C, acc);
        send_byte(8'h77, acc);
        t = 0;
        while (!(mon_in_frame && mon_bits == 5 && ps2_clk_out) && t < 500) begin
            @(negedge clk_sys);
            t++;
        end
        check("reached_bit5", 32'(mon_in_frame && mon_bits == 5), 1);
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clk_sys);
        check("abort_clk", ps2_clk_out, 1);
        check("abort_dat", ps2_dat_out, 1);
        check("abort_ready", din_ready, 0);
        check("abort_busy", busy, 0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        base    = start_q.size();
        @(negedge clk_sys);
        check("post_abort_ready", din_ready, 1);
        check("post_abort_busy", busy, 0);
        repeat (250) @(negedge clk_sys);
        check("no_resumed_frame", start_q.size(), base);
        check("post_abort_idle_busy", busy, 0);
        check("post_abort_dat", ps2_dat_out, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
